// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display path.
package seg_pkg;

  typedef enum logic {BLANK, SHOW} scan_st_t;

  localparam int unsigned NDIG = 4;

  localparam logic [7:0] SEG_ZERO = 8'h3F;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  // Active-high digit patterns, bit0=a .. bit6=g, bit7=dp.
  localparam logic [7:0] SEG_D0 = 8'h3F;
  localparam logic [7:0] SEG_D1 = 8'h06;
  localparam logic [7:0] SEG_D2 = 8'h5B;
  localparam logic [7:0] SEG_D3 = 8'h4F;
  localparam logic [7:0] SEG_D4 = 8'h66;
  localparam logic [7:0] SEG_D5 = 8'h6D;
  localparam logic [7:0] SEG_D6 = 8'h7D;
  localparam logic [7:0] SEG_D7 = 8'h07;
  localparam logic [7:0] SEG_D8 = 8'h7F;
  localparam logic [7:0] SEG_D9 = 8'h6F;

  // BCD digit to segment pattern; non-decimal codes render dark.
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'd0:    p = SEG_D0;
      4'd1:    p = SEG_D1;
      4'd2:    p = SEG_D2;
      4'd3:    p = SEG_D3;
      4'd4:    p = SEG_D4;
      4'd5:    p = SEG_D5;
      4'd6:    p = SEG_D6;
      4'd7:    p = SEG_D7;
      4'd8:    p = SEG_D8;
      4'd9:    p = SEG_D9;
      default: p = SEG_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppress mask: a digit is hidden only if it and every more
// significant digit show a bare zero. Digit 0 is never hidden.
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter bit LZB = 1'b0
) (
  input  logic [7:0]      f3,
  input  logic [7:0]      f2,
  input  logic [7:0]      f1,
  output logic [NDIG-1:0] mask
);

  logic s3, s2, s1;

  // Chain the zero tests from the most significant digit downwards.
  always_comb begin
    s3   = (f3 == SEG_ZERO);
    s2   = s3 && (f2 == SEG_ZERO);
    s1   = s2 && (f1 == SEG_ZERO);
    mask = LZB ? {s3, s2, s1, 1'b0} : '0;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes four snapshotted segment patterns onto one bus with
// active-low anode enables and a dark gap before every digit.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned SHOW_CYC  = 50000,
  parameter bit          LZB       = 1'b0,
  parameter bit          SEG_INV   = 1'b0
) (
  input  logic       TIMER,
  input  logic       BUTTON_N,
  input  logic [7:0] A0,
  input  logic [7:0] A1,
  input  logic [7:0] A2,
  input  logic [7:0] A3,
  output logic [7:0] SEG,
  output logic [3:0] AN
);

  localparam int unsigned MaxCyc = (BLANK_CYC > SHOW_CYC) ? BLANK_CYC : SHOW_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(SHOW_CYC - 1);
  localparam logic [7:0]      SegMask   = {8{SEG_INV}};

  scan_st_t        st_q, st_d;
  logic [1:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      frame_q [NDIG];
  logic [7:0]      frame_d [NDIG];
  logic [3:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic [NDIG-1:0] lz_mask;
  logic            snap;

  // Mask is taken from the next frame contents so it lines up with the
  // registered outputs below.
  seg_lz_mask #(
    .LZB (LZB)
  ) u_lz_mask (
    .f3   (frame_d[3]),
    .f2   (frame_d[2]),
    .f1   (frame_d[1]),
    .mask (lz_mask)
  );

  // State, counter and frame registers.
  always_ff @(posedge TIMER or negedge BUTTON_N) begin
    if (!BUTTON_N) begin
      st_q    <= BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      frame_q <= '{default: SEG_OFF};
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // Next-state: blank/show phase sequencing plus the once-per-frame snapshot.
  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CntW'(1);
    frame_d = frame_q;
    snap    = (st_q == BLANK) && (idx_q == 2'd0) && (cnt_q == '0);
    if (snap) begin
      frame_d[0] = A0;
      frame_d[1] = A1;
      frame_d[2] = A2;
      frame_d[3] = A3;
    end
    unique case (st_q)
      BLANK: begin
        if (cnt_q == BlankLast) begin
          st_d  = SHOW;
          cnt_d = '0;
        end
      end
      SHOW: begin
        if (cnt_q == ShowLast) begin
          st_d  = BLANK;
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        st_d  = BLANK;
        cnt_d = '0;
      end
    endcase
  end

  // Output decode from the next state so SEG/AN can be registered glitch-free
  // and still change on the same edge as the state.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_OFF ^ SegMask;
    if (st_d == SHOW) begin
      seg_d = frame_d[idx_d] ^ SegMask;
      if (!lz_mask[idx_d]) begin
        an_d = ~(4'b0001 << idx_d);
      end
    end
  end

  // Output registers; reset darkens the display without waiting for a clock.
  always_ff @(posedge TIMER or negedge BUTTON_N) begin
    if (!BUTTON_N) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF ^ SegMask;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench: stimulus queues the expected lit windows, a negedge monitor
// pops one entry at the start of every lit window and checks it.
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic [7:0] a     [3][4];
  logic [7:0] seg   [3];
  logic [3:0] an    [3];

  int checks = 0;
  int errors = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [11:0] q2[$];

  always #5 clk = ~clk;

  // DUT 0: plain; DUT 1: leading-zero blanking; DUT 2: inverted segments.
  seg_scan_mux #(.BLANK_CYC(2), .SHOW_CYC(3), .LZB(1'b0), .SEG_INV(1'b0)) u_base (
    .TIMER(clk), .BUTTON_N(rst_n[0]), .A0(a[0][0]), .A1(a[0][1]), .A2(a[0][2]),
    .A3(a[0][3]), .SEG(seg[0]), .AN(an[0])
  );
  seg_scan_mux #(.BLANK_CYC(2), .SHOW_CYC(3), .LZB(1'b1), .SEG_INV(1'b0)) u_lzb (
    .TIMER(clk), .BUTTON_N(rst_n[1]), .A0(a[1][0]), .A1(a[1][1]), .A2(a[1][2]),
    .A3(a[1][3]), .SEG(seg[1]), .AN(an[1])
  );
  seg_scan_mux #(.BLANK_CYC(2), .SHOW_CYC(3), .LZB(1'b0), .SEG_INV(1'b1)) u_inv (
    .TIMER(clk), .BUTTON_N(rst_n[2]), .A0(a[2][0]), .A1(a[2][1]), .A2(a[2][2]),
    .A3(a[2][3]), .SEG(seg[2]), .AN(an[2])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  task automatic push_win(input int d, input logic [3:0] ean, input logic [7:0] eseg);
    case (d)
      0:       q0.push_back({ean, eseg});
      1:       q1.push_back({ean, eseg});
      default: q2.push_back({ean, eseg});
    endcase
  endtask

  task automatic pop_exp(input int d, output logic [11:0] e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (d)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Plain frame: the first nd digits in scan order, active-high patterns.
  task automatic push_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] p3, input int nd);
    if (nd > 0) push_win(0, 4'b1110, p0);
    if (nd > 1) push_win(0, 4'b1101, p1);
    if (nd > 2) push_win(0, 4'b1011, p2);
    if (nd > 3) push_win(0, 4'b0111, p3);
  endtask

  // Monitor state, per DUT.
  bit          in_win [3];
  bit          gap_ok [3];
  bit          w_has  [3];
  int          wlen   [3];
  int          dark   [3];
  logic [11:0] w_exp  [3];

  task automatic mon_step(input int d);
    logic [11:0] e;
    bit          ok;
    if (rst_n[d] !== 1'b1) begin
      in_win[d] = 1'b0;
      gap_ok[d] = 1'b0;
      dark[d]   = 0;
      return;
    end
    check($sformatf("an_onehot%0d", d), {31'd0, (an[d] == 4'hF) || $onehot(~an[d])}, 32'd1);
    if (an[d] != 4'hF) begin
      if (!in_win[d]) begin
        pop_exp(d, e, ok);
        if (!ok) begin
          fail_now($sformatf("unexpected_window%0d an=%0h seg=%0h", d, an[d], seg[d]));
        end else begin
          check($sformatf("win_an%0d", d), {28'd0, an[d]}, {28'd0, e[11:8]});
          check($sformatf("win_seg%0d", d), {24'd0, seg[d]}, {24'd0, e[7:0]});
        end
        if (gap_ok[d] && d != 1) check($sformatf("blank_len%0d", d), dark[d], 2);
        in_win[d] = 1'b1;
        wlen[d]   = 1;
        w_has[d]  = ok;
        w_exp[d]  = e;
      end else begin
        wlen[d]++;
        if (w_has[d]) begin
          check($sformatf("win_hold%0d", d), {20'd0, an[d], seg[d]}, {20'd0, w_exp[d]});
        end
      end
    end else begin
      if (in_win[d]) begin
        check($sformatf("show_len%0d", d), wlen[d], 3);
        in_win[d] = 1'b0;
        gap_ok[d] = 1'b1;
        dark[d]   = 1;
      end else begin
        dark[d]++;
      end
      if (d != 1) begin
        check($sformatf("blank_seg%0d", d), {24'd0, seg[d]}, (d == 2) ? 32'hFF : 32'h00);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) mon_step(d);
  end

  task automatic wait_an(input int d, input logic [3:0] v, input int budget, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      #2;
      if (an[d] == v) hit = 1'b1;
    end
    if (!hit) fail_now(nm);
  endtask

  task automatic wait_not(input int d, input logic [3:0] v, input int budget, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      #2;
      if (an[d] != v) hit = 1'b1;
    end
    if (!hit) fail_now(nm);
  endtask

  task automatic wait_empty(input int d, input int budget, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      #2;
      if (qsize(d) == 0) hit = 1'b1;
    end
    if (!hit) fail_now(nm);
  endtask

  // Finish the last queued window, then park the DUT in reset.
  task automatic retire(input int d, input string nm);
    wait_empty(d, 400, {nm, "_drain"});
    wait_an(d, 4'hF, 10, {nm, "_dark"});
    rst_n[d] = 1'b0;
  endtask

  initial begin
    logic [7:0] r [4];
    bit         hit;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      for (int k = 0; k < 4; k++) a[d][k] = 8'h00;
    end
    a[0][0] = 8'h3F; a[0][1] = 8'h06; a[0][2] = 8'h5B; a[0][3] = 8'h4F;
    a[1][0] = 8'h3F; a[1][1] = 8'h06; a[1][2] = 8'h3F; a[1][3] = 8'h3F;
    a[2][0] = 8'h3F; a[2][1] = 8'h06; a[2][2] = 8'h5B; a[2][3] = 8'h4F;
    #12;
    check("rst_an0", {28'd0, an[0]}, 32'hF);
    check("rst_seg0", {24'd0, seg[0]}, 32'h00);
    check("rst_an1", {28'd0, an[1]}, 32'hF);
    check("rst_an2", {28'd0, an[2]}, 32'hF);
    check("rst_seg2", {24'd0, seg[2]}, 32'hFF);

    // Base: three frames, A2 changes mid-frame 0, then digits 0..2 of frame 3.
    @(negedge clk);
    rst_n[0] = 1'b1;
    push_frame(8'h3F, 8'h06, 8'h5B, 8'h4F, 4);
    push_frame(8'h3F, 8'h06, 8'h66, 8'h4F, 4);
    push_frame(8'h3F, 8'h06, 8'h66, 8'h4F, 4);
    push_frame(8'h3F, 8'h06, 8'h66, 8'h4F, 3);
    @(posedge clk); #1;
    check("first_edge_dark", {28'd0, an[0]}, 32'hF);
    @(posedge clk); #1;
    check("first_lit_an", {28'd0, an[0]}, 32'hE);
    check("first_lit_seg", {24'd0, seg[0]}, 32'h3F);
    wait_an(0, 4'b1101, 30, "wait_digit1");
    a[0][2] = 8'h66;

    // Reset between edges while digit 2 of frame 3 is lit.
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (q0.size() == 0 && an[0] == 4'b1011) hit = 1'b1;
    end
    if (!hit) fail_now("wait_frame3_digit2");
    rst_n[0] = 1'b0;
    #1;
    check("async_rst_an", {28'd0, an[0]}, 32'hF);
    check("async_rst_seg", {24'd0, seg[0]}, 32'h00);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      r[k]    = 8'($urandom);
      a[0][k] = r[k];
    end
    rst_n[0] = 1'b1;
    push_frame(r[0], r[1], r[2], r[3], 4);
    @(posedge clk); #1;
    check("restart_edge_dark", {28'd0, an[0]}, 32'hF);
    @(posedge clk); #1;
    check("restart_lit_an", {28'd0, an[0]}, 32'hE);
    check("restart_lit_seg", {24'd0, seg[0]}, {24'd0, r[0]});

    // Random patterns, changed just after each snapshot; they show next frame.
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 4; k++) begin
        r[k]    = 8'($urandom);
        a[0][k] = r[k];
      end
      push_frame(r[0], r[1], r[2], r[3], 4);
      wait_not(0, 4'b1110, 10, "rand_leave_d0");
      wait_an(0, 4'b1110, 30, "rand_next_d0");
    end
    retire(0, "base");

    // Leading-zero blanking: 3F3F063F, then A2=06, then A3=BF.
    @(negedge clk);
    rst_n[1] = 1'b1;
    push_win(1, 4'b1110, 8'h3F);
    push_win(1, 4'b1101, 8'h06);
    wait_an(1, 4'b1110, 10, "lzb_f0_d0");
    a[1][2] = 8'h06;
    push_win(1, 4'b1110, 8'h3F);
    push_win(1, 4'b1101, 8'h06);
    push_win(1, 4'b1011, 8'h06);
    wait_not(1, 4'b1110, 10, "lzb_leave_d0");
    wait_an(1, 4'b1110, 30, "lzb_f1_d0");
    a[1][3] = 8'hBF;
    push_win(1, 4'b1110, 8'h3F);
    push_win(1, 4'b1101, 8'h06);
    push_win(1, 4'b1011, 8'h06);
    push_win(1, 4'b0111, 8'hBF);
    retire(1, "lzb");

    // Inverted segment bus.
    @(negedge clk);
    rst_n[2] = 1'b1;
    push_win(2, 4'b1110, 8'hC0);
    push_win(2, 4'b1101, 8'hF9);
    push_win(2, 4'b1011, 8'hA4);
    push_win(2, 4'b0111, 8'hB0);
    retire(2, "inv");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
